piece_sequencer: RTL
====================

// Module: piece_sequencer
// PURPOSE
//  Chooses which tetromino type the game spawns next and drives the 5-bit block-type code consumed by the pattern generator.
//  Uses a 7-bag randomiser: each group of 7 consecutive draws holds every piece exactly once. Keeps a preview queue for
//  the "next" display. Sits between the game-control FSM (spawn requester) and the block-pattern lookup.
// PARAMETERS
//  QUEUE_DEPTH  3         preview-queue entries, 1..6
//  LFSR_SEED    16'hACE1  LFSR value after reset; also used when a zero seed is loaded
// PORTS
//  clk                 in   1   system clock
//  rst_n               in   1   asynchronous active-low reset
//  spawn_req           in   1   level request for a new piece; held until spawn_valid
//  spawn_valid         out  1   1-cycle pulse: current_block_type was updated this cycle
//  current_block_type  out  5   active piece code 0..6 (I,O,S,Z,L,J,T); 7 = NONE, an empty pattern
//  next_block_type     out  5   head of the preview queue; 7 while not filled
//  seed_load           in   1   1-cycle pulse: load seed and restart the sequence
//  seed                in   16  seed value
//  hold_req            in   1   1-cycle pulse: swap the active piece with the hold slot
//  hold_type           out  5   piece in the hold slot; 7 = empty
//  busy                out  1   high whenever state != READY
// BEHAVIOUR
//  Reset (async): state=FILL, lfsr=LFSR_SEED, bag=7'h7F, queue all 7, current/next/hold_type=7, spawn_valid=0, hold_ok=1.
//  LFSR: 16-bit Galois, taps 16'hB400. Advances every cycle unless seed_load is high.
//  Draw (1 cycle): c = lfsr[2:0], with 7 mapped to 0. Pick the first set bag bit at index >= c, wrapping 6->0.
//   Clear that bit. If the bag would become 0, it reloads to 7'h7F in the same cycle.
//  FILL: one draw per cycle into the queue tail. After QUEUE_DEPTH cycles go to READY. spawn_req is not sampled here.
//  READY: spawn_req=1 -> ISSUE; else hold_req=1 and hold_ok -> HOLD; else stay.
//  ISSUE (1 cycle): current <= queue[0], queue shifts, one draw fills the tail, spawn_valid=1, hold_ok<=1, then READY.
//   Latency: request sampled in cycle N -> spawn_valid and new current in cycle N+1.
//   The requester drops spawn_req after it sees spawn_valid. A request still high in READY counts as a new request.
//  Simultaneous spawn_req and hold_req in READY: spawn wins and the hold is discarded.
//  hold_req outside READY is discarded.
//  seed_load, any state: lfsr <= (seed==0 ? LFSR_SEED : seed), bag=7'h7F, queue and current cleared to 7,
//   hold cleared to 7, then FILL. Beats every other event in the same cycle.
//  spawn_req in READY while current=7 is legal; this is the first spawn.
// CONFIGURATION
//  PIECE_HOLD_EN defined:
//   HOLD (1 cycle): if hold_type==7, hold<=current and current<=queue[0], with shift plus draw as in ISSUE.
//   Otherwise current and hold swap. In both cases spawn_valid=1, hold_ok<=0, then READY.
//   hold_ok is set again only by ISSUE. hold_req while hold_ok=0 is ignored.
//  PIECE_HOLD_EN undefined: HOLD state absent, hold_req ignored, hold_type tied to 5'd7. Ports are kept.
// STRUCTURE
//  piece_pkg: typedef enum logic [4:0] piece_t {P_I=0,P_O,P_S,P_Z,P_L,P_J,P_T,P_NONE=7}.
//   Also NUM_PIECES=7, BAG_FULL=7'h7F, LFSR_TAPS=16'hB400, typedef enum seq_state_t {FILL,READY,ISSUE,HOLD}.
//  Sub-module piece_lfsr: 16-bit Galois LFSR with load and enable. Bag pick, queue and FSM live in piece_sequencer.
// TESTING
//  1 Reset, QUEUE_DEPTH=3 -> busy=1 for exactly 3 cycles; current=7; next in 0..6 once READY.
//  2 28 spawns after reset -> every aligned group of 7 spawned types is a permutation of 0..6.
//    Sequence matches the reference model bit-for-bit.
//  3 spawn_req rises in READY at cycle N -> spawn_valid=1 only at N+1, current==prior next.
//    Holding req 1 extra cycle -> second spawn at N+3.
//  4 seed_load with seed=0 -> busy 3 cycles; following 7 spawns equal the post-reset sequence.
//    seed=16'h1234 -> a different sequence.
//  5 PIECE_HOLD_EN: hold with empty slot -> hold_type=old current, current=old next. Second hold before spawn ignored.
//    After a spawn, hold swaps the pieces. Without the macro, hold_type stays 7.
//  6 rst_n low during ISSUE -> outputs return to reset values asynchronously; no spawn_valid after release until a new request.

Source files
------------

// File: rtl/piece_pkg.sv
//----------------------------------------------------------------------------
// piece_pkg: piece codes, sequencer states and the 7-bag pick helper. Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

package piece_pkg;

   typedef enum logic [4:0] {
      P_I    = 5'd0,
      P_O    = 5'd1,
      P_S    = 5'd2,
      P_Z    = 5'd3,
      P_L    = 5'd4,
      P_J    = 5'd5,
      P_T    = 5'd6,
      P_NONE = 5'd7
   } piece_t;

   localparam int          NUM_PIECES = 7;
   localparam logic [6:0]  BAG_FULL   = 7'h7F;
   localparam logic [15:0] LFSR_TAPS  = 16'hB400;

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      READY = 2'd1,
      ISSUE = 2'd2,
      HOLD  = 2'd3
   } seq_state_t;

   // First piece still in the bag at or after the start index, wrapping 6->0.
   function automatic logic [2:0] bag_pick(input logic [6:0] bag, input logic [2:0] start);
      logic [2:0] s;
      logic [2:0] idx;
      logic       found;
      int         cand;
      s     = (start == 3'd7) ? 3'd0 : start;
      idx   = 3'd0;
      found = 1'b0;
      for (int k = 0; k < NUM_PIECES; k++) begin
         cand = int'(s) + k;
         if (cand >= NUM_PIECES) cand = cand - NUM_PIECES;
         if (!found && bag[cand[2:0]]) begin
            idx   = cand[2:0];
            found = 1'b1;
         end
      end
      return idx;
   endfunction

endpackage

`default_nettype wire

// File: rtl/piece_sequencer_if.sv
//----------------------------------------------------------------------------
// piece_sequencer_if: spawn/hold/seed handshake between game control and sequencer. Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

interface piece_sequencer_if;

   logic                 spawn_req;
   logic                 spawn_valid;
   piece_pkg::piece_t    current_block_type;
   piece_pkg::piece_t    next_block_type;
   logic                 seed_load;
   logic [15:0]          seed;
   logic                 hold_req;
   piece_pkg::piece_t    hold_type;
   logic                 busy;

   modport master (
      output spawn_req, seed_load, seed, hold_req,
      input  spawn_valid, current_block_type, next_block_type, hold_type, busy
   );

   modport slave (
      input  spawn_req, seed_load, seed, hold_req,
      output spawn_valid, current_block_type, next_block_type, hold_type, busy
   );

endinterface

`default_nettype wire

// File: rtl/piece_lfsr.sv
//----------------------------------------------------------------------------
// piece_lfsr: 16-bit right-shifting Galois LFSR with synchronous load and enable. Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

module piece_lfsr #(
   parameter logic [15:0] SEED = 16'hACE1,
   parameter logic [15:0] TAPS = 16'hB400
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load_i,
   input  logic [15:0] load_val_i,
   input  logic        en_i,
   output logic [15:0] lfsr_o
);

   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (load_i) begin
         lfsr_d = load_val_i;
      end else if (en_i) begin
         lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : 16'h0000);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign lfsr_o = lfsr_q;

endmodule

`default_nettype wire

// File: rtl/piece_sequencer.sv
//----------------------------------------------------------------------------
// piece_sequencer: 7-bag tetromino sequencer with preview queue; PIECE_HOLD_EN adds a hold slot. Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

module piece_sequencer
   import piece_pkg::*;
#(
   parameter int          QUEUE_DEPTH = 3,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input  logic             clk,
   input  logic             rst_n,
   piece_sequencer_if.slave bus
);

   seq_state_t  state_q, state_d;
   logic [6:0]  bag_q, bag_d;
   piece_t      queue_q [QUEUE_DEPTH];
   piece_t      queue_d [QUEUE_DEPTH];
   piece_t      current_q, current_d;
   logic        spawn_valid_q, spawn_valid_d;
   logic [2:0]  fill_cnt_q, fill_cnt_d;
`ifdef PIECE_HOLD_EN
   piece_t      hold_q, hold_d;
   logic        hold_ok_q, hold_ok_d;
`endif

   logic [15:0] w_lfsr;
   logic [15:0] w_seed_val;
   logic [2:0]  w_pick;
   piece_t      w_draw;
   logic [6:0]  w_bag_left;
   logic [6:0]  w_bag_next;
   logic        w_shift;
   logic [12:0] w_unused_lfsr;

   assign w_seed_val = (bus.seed == 16'h0000) ? LFSR_SEED : bus.seed;

   piece_lfsr #(
      .SEED (LFSR_SEED),
      .TAPS (LFSR_TAPS)
   ) u_lfsr (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (bus.seed_load),
      .load_val_i (w_seed_val),
      .en_i       (1'b1),
      .lfsr_o     (w_lfsr)
   );

   assign w_unused_lfsr = w_lfsr[15:3];
   assign w_pick        = bag_pick(bag_q, w_lfsr[2:0]);
   assign w_draw        = piece_t'({2'b00, w_pick});
   assign w_bag_left    = bag_q & ~(7'd1 << w_pick);
   assign w_bag_next    = (w_bag_left == 7'd0) ? BAG_FULL : w_bag_left;

   // Spawn/hold results are registered on entry to ISSUE/HOLD so they are visible during that state.
   always_comb begin
      state_d       = state_q;
      bag_d         = bag_q;
      queue_d       = queue_q;
      current_d     = current_q;
      spawn_valid_d = 1'b0;
      fill_cnt_d    = fill_cnt_q;
      w_shift       = 1'b0;
`ifdef PIECE_HOLD_EN
      hold_d        = hold_q;
      hold_ok_d     = hold_ok_q;
`endif
      if (bus.seed_load) begin
         state_d    = FILL;
         bag_d      = BAG_FULL;
         fill_cnt_d = 3'd0;
         current_d  = P_NONE;
         for (int i = 0; i < QUEUE_DEPTH; i++) queue_d[i] = P_NONE;
`ifdef PIECE_HOLD_EN
         hold_d     = P_NONE;
         hold_ok_d  = 1'b1;
`endif
      end else begin
         case (state_q)
            FILL: begin
               w_shift = 1'b1;
               if (fill_cnt_q == 3'(QUEUE_DEPTH - 1)) begin
                  state_d    = READY;
                  fill_cnt_d = 3'd0;
               end else begin
                  fill_cnt_d = fill_cnt_q + 3'd1;
               end
            end
            READY: begin
               if (bus.spawn_req) begin
                  current_d     = queue_q[0];
                  w_shift       = 1'b1;
                  spawn_valid_d = 1'b1;
                  state_d       = ISSUE;
`ifdef PIECE_HOLD_EN
                  hold_ok_d     = 1'b1;
               end else if (bus.hold_req && hold_ok_q) begin
                  hold_d = current_q;
                  if (hold_q == P_NONE) begin
                     current_d = queue_q[0];
                     w_shift   = 1'b1;
                  end else begin
                     current_d = hold_q;
                  end
                  spawn_valid_d = 1'b1;
                  hold_ok_d     = 1'b0;
                  state_d       = HOLD;
`endif
               end
            end
            default: state_d = READY;
         endcase

         if (w_shift) begin
            for (int i = 0; i < QUEUE_DEPTH - 1; i++) queue_d[i] = queue_q[i + 1];
            queue_d[QUEUE_DEPTH - 1] = w_draw;
            bag_d                    = w_bag_next;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= FILL;
         bag_q         <= BAG_FULL;
         for (int i = 0; i < QUEUE_DEPTH; i++) queue_q[i] <= P_NONE;
         current_q     <= P_NONE;
         spawn_valid_q <= 1'b0;
         fill_cnt_q    <= 3'd0;
`ifdef PIECE_HOLD_EN
         hold_q        <= P_NONE;
         hold_ok_q     <= 1'b1;
`endif
      end else begin
         state_q       <= state_d;
         bag_q         <= bag_d;
         queue_q       <= queue_d;
         current_q     <= current_d;
         spawn_valid_q <= spawn_valid_d;
         fill_cnt_q    <= fill_cnt_d;
`ifdef PIECE_HOLD_EN
         hold_q        <= hold_d;
         hold_ok_q     <= hold_ok_d;
`endif
      end
   end

   assign bus.spawn_valid        = spawn_valid_q;
   assign bus.current_block_type = current_q;
   assign bus.next_block_type    = queue_q[0];
   assign bus.busy               = (state_q != READY);

`ifdef PIECE_HOLD_EN
   assign bus.hold_type = hold_q;
`else
   logic w_unused_hold;
   assign bus.hold_type = P_NONE;
   assign w_unused_hold = bus.hold_req;
`endif

endmodule

`default_nettype wire
